// File: rtl/mul_iter_unit.sv
// Multi-cycle MUL/MLA unit for the nnARM datapath: radix-2 shift-add with early exit.
// Drives the running product and shifted multiplicand into a word adder each iteration.
module mul_iter_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_Start,
    input  logic             in_Accumulate,
    input  logic [WIDTH-1:0] in_Multiplicand,
    input  logic [WIDTH-1:0] in_Multiplier,
    input  logic [WIDTH-1:0] in_AccValue,
    output logic             out_Busy,
    output logic             out_Done,
    output logic [WIDTH-1:0] out_Result,
    output logic             out_Neg,
    output logic             out_Zero
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ITER = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] COUNT_LAST = CNT_W'(WIDTH);
    localparam logic [WIDTH-1:0] ZERO_WORD  = {WIDTH{1'b0}};

    // Word adder; the carry out is dropped so the sum wraps modulo 2^WIDTH.
    function automatic logic [WIDTH-1:0] word_add(
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b,
        input logic             low_carry
    );
        return a + b + {{(WIDTH-1){1'b0}}, low_carry};
    endfunction

    state_t             state_r;
    logic [WIDTH-1:0]   mcand_r;
    logic [WIDTH-1:0]   mplier_r;
    logic [WIDTH-1:0]   prod_r;
    logic [CNT_W-1:0]   count_r;

    logic [WIDTH-1:0]   sum_s;
    logic [WIDTH-1:0]   prod_next_s;
    logic [WIDTH-1:0]   mplier_shift_s;
    logic [CNT_W-1:0]   count_next_s;
    logic               iter_last_s;

    // Per-iteration datapath: conditional add, shifted multiplier, exit test.
    always_comb begin
        sum_s          = word_add(prod_r, mcand_r, 1'b0);
        mplier_shift_s = mplier_r >> 1'b1;
        count_next_s   = count_r + {{(CNT_W-1){1'b0}}, 1'b1};
        if (mplier_r[0]) begin
            prod_next_s = sum_s;
        end else begin
            prod_next_s = prod_r;
        end
        if ((mplier_shift_s == ZERO_WORD) || (count_next_s == COUNT_LAST)) begin
            iter_last_s = 1'b1;
        end else begin
            iter_last_s = 1'b0;
        end
    end

    // Control FSM with registered handshake and result outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            mcand_r    <= ZERO_WORD;
            mplier_r   <= ZERO_WORD;
            prod_r     <= ZERO_WORD;
            count_r    <= {CNT_W{1'b0}};
            out_Busy   <= 1'b0;
            out_Done   <= 1'b0;
            out_Result <= ZERO_WORD;
            out_Neg    <= 1'b0;
            out_Zero   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    out_Done <= 1'b0;
                    if (in_Start) begin
                        mcand_r  <= in_Multiplicand;
                        mplier_r <= in_Multiplier;
                        count_r  <= {CNT_W{1'b0}};
                        prod_r   <= in_Accumulate ? in_AccValue : ZERO_WORD;
                        out_Busy <= 1'b1;
                        // A zero multiplier needs no iterations at all.
                        state_r  <= (in_Multiplier == ZERO_WORD) ? ST_DONE : ST_ITER;
                    end else begin
                        state_r  <= ST_IDLE;
                    end
                end
                ST_ITER: begin
                    out_Done <= 1'b0;
                    prod_r   <= prod_next_s;
                    mcand_r  <= mcand_r << 1'b1;
                    mplier_r <= mplier_shift_s;
                    count_r  <= count_next_s;
                    state_r  <= iter_last_s ? ST_DONE : ST_ITER;
                end
                ST_DONE: begin
                    out_Result <= prod_r;
                    out_Neg    <= prod_r[WIDTH-1];
                    out_Zero   <= (prod_r == ZERO_WORD);
                    out_Done   <= 1'b1;
                    out_Busy   <= 1'b0;
                    state_r    <= ST_IDLE;
                end
                default: begin
                    out_Busy <= 1'b0;
                    out_Done <= 1'b0;
                    state_r  <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_iter_unit.sv
// Bench for mul_iter_unit: an arithmetic reference model checked every cycle,
// plus directed operations with hand-computed results and latencies.
module tb_mul_iter_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_Start;
    logic        in_Accumulate;
    logic [31:0] in_Multiplicand;
    logic [31:0] in_Multiplier;
    logic [31:0] in_AccValue;
    logic        out_Busy;
    logic        out_Done;
    logic [31:0] out_Result;
    logic        out_Neg;
    logic        out_Zero;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    mul_iter_unit #(.WIDTH(32), .CNT_W(6)) dut (
        .clock           (clock),
        .reset           (reset),
        .in_Start        (in_Start),
        .in_Accumulate   (in_Accumulate),
        .in_Multiplicand (in_Multiplicand),
        .in_Multiplier   (in_Multiplier),
        .in_AccValue     (in_AccValue),
        .out_Busy        (out_Busy),
        .out_Done        (out_Done),
        .out_Result      (out_Result),
        .out_Neg         (out_Neg),
        .out_Zero        (out_Zero)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Edges from start to done: highest set multiplier bit index + 2 (1 for zero).
    function automatic int lat_of(input logic [31:0] m);
        int k = 0;
        for (int i = 0; i < 32; i++) begin
            if (m[i]) k = i + 1;
        end
        return k + 1;
    endfunction

    logic        m_busy = 1'b0;
    logic        m_done = 1'b0;
    logic        m_neg  = 1'b0;
    logic        m_zero = 1'b0;
    logic [31:0] m_result = 32'd0;
    logic [31:0] m_pend   = 32'd0;
    int          m_left   = 0;

    always @(posedge clock) begin
        if (reset) begin
            m_busy   <= 1'b0;
            m_done   <= 1'b0;
            m_neg    <= 1'b0;
            m_zero   <= 1'b0;
            m_result <= 32'd0;
            m_left   <= 0;
        end else begin
            m_done <= 1'b0;
            if (!m_busy) begin
                if (in_Start) begin
                    m_busy <= 1'b1;
                    m_left <= lat_of(in_Multiplier);
                    m_pend <= in_Multiplicand * in_Multiplier + (in_Accumulate ? in_AccValue : 32'd0);
                end
            end else if (m_left == 1) begin
                m_busy   <= 1'b0;
                m_done   <= 1'b1;
                m_result <= m_pend;
                m_neg    <= m_pend[31];
                m_zero   <= (m_pend == 32'd0);
                m_left   <= 0;
            end else begin
                m_left <= m_left - 1;
            end
        end
    end

    always @(negedge clock) begin
        if (chk_en) begin
            check("busy",   {31'd0, out_Busy}, {31'd0, m_busy});
            check("done",   {31'd0, out_Done}, {31'd0, m_done});
            check("result", out_Result, m_result);
            check("neg",    {31'd0, out_Neg},  {31'd0, m_neg});
            check("zero",   {31'd0, out_Zero}, {31'd0, m_zero});
        end
    end

    task automatic do_op(input string name, input logic acc, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] accv,
                         input logic [31:0] exp_res, input int exp_lat,
                         input logic exp_n, input logic exp_z, input bit poke);
        int lat = 0;
        in_Start        = 1'b1;
        in_Accumulate   = acc;
        in_Multiplicand = a;
        in_Multiplier   = b;
        in_AccValue     = accv;
        @(posedge clock);
        #2;
        in_Start        = 1'b0;
        in_Multiplicand = ~a;
        in_Multiplier   = ~b;
        in_AccValue     = ~accv;
        for (int n = 1; n <= 40 && lat == 0; n++) begin
            @(posedge clock);
            #1;
            if (poke && n == 4) begin
                in_Start        = 1'b1;
                in_Accumulate   = 1'b0;
                in_Multiplicand = 32'd5;
                in_Multiplier   = 32'd3;
            end
            if (poke && n == 5) in_Start = 1'b0;
            if (out_Done) lat = n;
        end
        check({name, " latency"}, 32'(lat), 32'(exp_lat));
        check({name, " value"},   out_Result, exp_res);
        check({name, " N"},       {31'd0, out_Neg},  {31'd0, exp_n});
        check({name, " Z"},       {31'd0, out_Zero}, {31'd0, exp_z});
    endtask

    initial begin
        int pulses;
        reset           = 1'b1;
        in_Start        = 1'b0;
        in_Accumulate   = 1'b0;
        in_Multiplicand = 32'd0;
        in_Multiplier   = 32'd0;
        in_AccValue     = 32'd0;
        repeat (2) @(posedge clock);
        #1;
        chk_en = 1'b1;
        check("reset busy",   {31'd0, out_Busy}, 32'd0);
        check("reset result", out_Result, 32'd0);
        reset = 1'b0;
        @(posedge clock);
        #1;

        do_op("mul3x5",   1'b0, 32'd3,          32'd5,          32'd0,          32'h0000000F, 4,  1'b0, 1'b0, 1'b0);
        do_op("mulneg",   1'b0, 32'hFFFFFFFD,   32'd7,          32'd0,          32'hFFFFFFEB, 4,  1'b1, 1'b0, 1'b0);
        do_op("mla_wrap", 1'b1, 32'h00010000,   32'h00010000,   32'd7,          32'h00000007, 18, 1'b0, 1'b0, 1'b0);
        do_op("mul_x0",   1'b0, 32'h00001234,   32'd0,          32'd0,          32'h00000000, 1,  1'b0, 1'b1, 1'b0);
        do_op("mla_x0",   1'b1, 32'h00005555,   32'd0,          32'h80000000,   32'h80000000, 1,  1'b1, 1'b0, 1'b0);
        repeat (3) @(posedge clock);
        #1;
        do_op("worst",    1'b0, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'd0,          32'h00000001, 33, 1'b0, 1'b0, 1'b1);

        // Reset lands on edge 10 of a 32-iteration operation.
        in_Start        = 1'b1;
        in_Multiplicand = 32'hFFFFFFFF;
        in_Multiplier   = 32'hFFFFFFFF;
        @(posedge clock);
        #1;
        in_Start = 1'b0;
        repeat (9) @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock);
        #1;
        check("rst busy",   {31'd0, out_Busy}, 32'd0);
        check("rst done",   {31'd0, out_Done}, 32'd0);
        check("rst result", out_Result, 32'd0);
        reset  = 1'b0;
        pulses = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clock);
            #1;
            if (out_Done) pulses++;
        end
        check("rst no done", 32'(pulses), 32'd0);
        do_op("after_rst", 1'b0, 32'd2, 32'd2, 32'd0, 32'h00000004, 3, 1'b0, 1'b0, 1'b0);

        repeat (2) @(posedge clock);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mul_iter_unit.md
Name: mul_iter_unit

Overview:
- Multi-cycle MUL/MLA execution unit for the nnARM datapath.
- Sits directly upstream of the WordAdder. Each iteration it drives the adder operands (running product, shifted multiplicand) and consumes the adder's sum.
- Radix-2 shift-add with early termination. Produces the low 32 bits of the product (plus optional accumulate) and N/Z flags for the CPSR update path.
- Start/Busy/Done handshake with the issue stage.

Parameters:
- WIDTH, 32 (`WordWidth): operand and result width.
- CNT_W, 6: iteration counter width; must hold WIDTH.

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- in_Start  in  1  request; sampled only while idle.
- in_Accumulate  in  1  1 = MLA (product + in_AccValue), 0 = MUL.
- in_Multiplicand  in  WIDTH  Rm operand.
- in_Multiplier  in  WIDTH  Rs operand.
- in_AccValue  in  WIDTH  Rn operand; used only when in_Accumulate=1.
- out_Busy  out  1  operation in progress.
- out_Done  out  1  one-cycle pulse; result and flags valid.
- out_Result  out  WIDTH  low WIDTH bits of the result; held until the next done.
- out_Neg  out  1  out_Result[WIDTH-1], registered with out_Done.
- out_Zero  out  1  out_Result==0, registered with out_Done.

Behaviour:
- Reset (synchronous, active-high): state IDLE; out_Busy, out_Done, out_Result, out_Neg, out_Zero all 0; internal registers cleared. Reset overrides everything, including mid-operation; the in-flight operation is discarded with no done pulse.
- States: IDLE, ITER, DONE.
- IDLE: at edge 0 with in_Start=1, capture the operands:
  - mcand <= in_Multiplicand; mplier <= in_Multiplier; count <= 0.
  - prod <= in_AccValue if in_Accumulate, else 0.
  - out_Busy <= 1.
  - Next state is DONE if in_Multiplier==0, else ITER.
- ITER, one iteration per edge:
  - If mplier[0], prod <= prod + mcand via WordAdder with in_LowCarry=0; carry and overflow are discarded (sum is modulo 2^WIDTH).
  - mcand <= mcand<<1; mplier <= mplier>>1 (logical); count <= count+1.
  - Leave for DONE when the shifted mplier is 0 or count reaches WIDTH.
- DONE, one cycle: out_Result <= prod; out_Neg and out_Zero derived from prod; out_Done <= 1; out_Busy <= 0; next state IDLE.
- Latency: let k = index of the multiplier's highest set bit + 1 (k=0 for a zero multiplier). Iterations occur at edges 1..k; done and result are registered at edge k+1. Maximum is WIDTH+1 edges.
- out_Done is high for exactly one cycle. A new in_Start may be sampled at the edge after the done edge (back-to-back allowed).
- in_Start while out_Busy=1 is ignored. Operand inputs are don't-care except at the start edge.
- out_Result/out_Neg/out_Zero change only at a done edge or on reset.
- Signed and unsigned operands give identical low-WIDTH results; no sign handling is required.
- Carry and overflow flags are not produced. The CPSR stage keeps C and V.

Test Plan:
- MUL 3*5, start at edge 0 -> busy at edges 0..3, done pulse at edge 4; result 0x0000000F, N=0, Z=0.
- MUL 0xFFFFFFFD*7 -> done at edge 4; result 0xFFFFFFEB, N=1, Z=0.
- MLA 0x00010000*0x00010000 + 7 -> wrap discarded; result 0x00000007, done at edge 18.
- Zero multiplier: MUL x*0 -> done at edge 1, result 0, Z=1. MLA x*0 + 0x80000000 -> result 0x80000000, N=1.
- Worst case: 0xFFFFFFFF*0xFFFFFFFF -> 32 iterations, done at edge 33, result 0x00000001. A second in_Start at edge 5 has no effect.
- Reset mid-operation: assert reset at edge 10 of a 32-iteration op -> busy=0, result 0, no done pulse. A new MUL 2*2 after reset -> result 4 at edge 3.
